alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_slice.sv | 49 ++++
 rtl/alu_multicycle.sv | 172 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, FSM state type and ctrl decode helpers for the multi-cycle ALU.
// ALU_SLT_EN enables the set-less-than operation.
package alu_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    // Result bit that carries the SLT outcome
    localparam int unsigned SLT_LESS_POS = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic ctrl_legal(input logic [3:0] c);
        case (c)
            CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_NOR: return 1'b1;
`ifdef ALU_SLT_EN
            CTRL_SLT: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ctrl_arith(input logic [3:0] c);
        return (c == CTRL_ADD) || (c == CTRL_SUB);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice; reused every RUN cycle by the multi-cycle ALU.
// ALU_SLT_EN enables the less-bit result path.
module alu_slice
    import alu_pkg::*;
#(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic [SLICE-1:0] less_i,
    input  logic             cin_i,
    input  logic [3:0]       ctrl_i,
    output logic [SLICE-1:0] res_o,
    output logic             cout_o,
    output logic             msb_cin_o
);

    logic [SLICE-1:0] a_m;
    logic [SLICE-1:0] b_m;
    logic [SLICE:0]   total;

    assign a_m   = ctrl_i[3] ? ~a_i : a_i;
    assign b_m   = ctrl_i[2] ? ~b_i : b_i;
    assign total = {1'b0, a_m} + {1'b0, b_m} + (SLICE+1)'(cin_i);

    assign cout_o    = total[SLICE];
    // Carry into the slice MSB recovered from the sum bit
    assign msb_cin_o = total[SLICE-1] ^ a_m[SLICE-1] ^ b_m[SLICE-1];

`ifndef ALU_SLT_EN
    logic unused_less;
    assign unused_less = ^less_i;
`endif

    always_comb begin
        res_o = '0;
        case (ctrl_i[1:0])
            2'b00:   res_o = a_m & b_m;
            2'b01:   res_o = a_m | b_m;
            2'b10:   res_o = total[SLICE-1:0];
`ifdef ALU_SLT_EN
            default: res_o = less_i;
`else
            default: res_o = '0;
`endif
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU processing SLICE bits per cycle through one shared alu_slice.
// ALU_SLT_EN enables SLT (ctrl 0111); otherwise that code is treated as illegal.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int unsigned NSLICE   = WIDTH / SLICE;
    localparam int unsigned IDX_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
        $error("alu_multicycle: WIDTH must be a multiple of SLICE");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [SLICE-1:0] slice_res;
    logic             slice_cout;
    logic             slice_msb_cin;
    logic [WIDTH-1:0] fin_res;
    logic             fin_cout;
    logic             fin_ovf;

    alu_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i       (a_q[32'(idx_q) * SLICE +: SLICE]),
        .b_i       (b_q[32'(idx_q) * SLICE +: SLICE]),
        .less_i    ('0),
        .cin_i     (carry_q),
        .ctrl_i    (ctrl_q),
        .res_o     (slice_res),
        .cout_o    (slice_cout),
        .msb_cin_o (slice_msb_cin)
    );

`ifdef ALU_SLT_EN
    // Sign of A-B, valid on the final slice
    logic slt_set;
    assign slt_set = a_q[WIDTH-1] ^ ctrl_q[3] ^ b_q[WIDTH-1] ^ ctrl_q[2] ^ slice_msb_cin;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        acc_d    = acc_q;
        result_d = result_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        fin_res  = '0;
        fin_cout = 1'b0;
        fin_ovf  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    a_d     = src1_i;
                    b_d     = src2_i;
                    ctrl_d  = ctrl_i;
                    idx_d   = '0;
                    carry_d = ctrl_i[2];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d[32'(idx_q) * SLICE +: SLICE] = slice_res;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                    fin_res = acc_d;
                    if (ctrl_arith(ctrl_q)) begin
                        fin_cout = slice_cout;
                        fin_ovf  = slice_msb_cin ^ slice_cout;
                    end
`ifdef ALU_SLT_EN
                    else if (ctrl_q == CTRL_SLT) begin
                        fin_res = '0;
                        fin_res[SLT_LESS_POS] = slt_set ^ slice_msb_cin ^ slice_cout;
                    end
`endif
                    else if (!ctrl_legal(ctrl_q)) begin
                        fin_res = '0;
                    end
                    result_d = fin_res;
                    zero_d   = (fin_res == '0);
                    cout_d   = fin_cout;
                    ovf_d    = fin_ovf;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (32/8 instance plus an 8/8 single-slice instance).
module tb_alu_multicycle;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic [3:0]  ctrl = '0;
    logic        busy, done, zero, cout, ovf;
    logic [31:0] res;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  ctrl8 = '0;
    logic        busy8, done8, zero8, cout8, ovf8;
    logic [7:0]  res8;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(32), .SLICE(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .src1_i(a), .src2_i(b), .ctrl_i(ctrl),
        .busy_o(busy), .done_o(done), .result_o(res), .zero_o(zero), .cout_o(cout),
        .overflow_o(ovf)
    );

    alu_multicycle #(.WIDTH(8), .SLICE(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .src1_i(a8), .src2_i(b8), .ctrl_i(ctrl8),
        .busy_o(busy8), .done_o(done8), .result_o(res8), .zero_o(zero8), .cout_o(cout8),
        .overflow_o(ovf8)
    );

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c);
        exp_t        e;
        logic [31:0] ax, by;
        logic [32:0] s;
        longint      ss;
        ax = c[3] ? ~x : x;
        by = c[2] ? ~y : y;
        s  = {1'b0, ax} + {1'b0, by} + 33'(c[2]);
        ss = longint'($signed(ax)) + longint'($signed(by)) + longint'(c[2]);
        e  = '0;
        case (c)
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b0010, 4'b0110: begin
                e.res  = s[31:0];
                e.cout = s[32];
                e.ovf  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
`ifdef ALU_SLT_EN
            4'b0111: e.res = {31'b0, $signed(x) < $signed(y)};
`endif
            4'b1100: e.res = ~(x | y);
            default: e.res = '0;
        endcase
        e.zero = (e.res == 32'h0);
        return e;
    endfunction

    // Drive one start pulse; inputs are scrambled right after acceptance
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c, input bit push);
        @(negedge clk);
        a = x; b = y; ctrl = c; start = 1'b1;
        if (push) sb.push_back(model(x, y, c));
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; ctrl = 4'($urandom);
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] c,
                          output exp_t obs, output int lat);
        issue(x, y, c, 1'b1);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        obs = {res, zero, cout, ovf};
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (res !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", res); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL reset_zero got %b want 1", zero); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL reset_cout got %b want 0", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
        rst = 1'b0;
    endtask

    task automatic test_arith;
        exp_t obs, e;
        int   lat;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, CTRL_ADD, obs, lat);
        e = sb.pop_front();
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL add_latency got %0d want 5", lat); end
        n_cmp++; if (obs !== e) begin n_bad++;
            $display("FAIL add_carry got %h/%b%b%b want %h/%b%b%b", obs.res, obs.zero, obs.cout, obs.ovf, e.res, e.zero, e.cout, e.ovf); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width got %b want 0", done); end
        run_op(32'h8000_0000, 32'h0000_0001, CTRL_SUB, obs, lat);
        e = sb.pop_front();
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL sub_latency got %0d want 5", lat); end
        n_cmp++; if (obs !== e) begin n_bad++;
            $display("FAIL sub_overflow got %h/%b%b%b want %h/%b%b%b", obs.res, obs.zero, obs.cout, obs.ovf, e.res, e.zero, e.cout, e.ovf); end
    endtask

    task automatic test_slt;
        exp_t obs, e;
        int   lat;
        run_op(32'hFFFF_FFFB, 32'h0000_0003, 4'b0111, obs, lat);
        e = sb.pop_front();
        n_cmp++; if (obs !== e || lat != 5) begin n_bad++;
            $display("FAIL slt_less got %h/%b%b%b lat %0d want %h/%b%b%b lat 5", obs.res, obs.zero, obs.cout, obs.ovf, lat, e.res, e.zero, e.cout, e.ovf); end
        run_op(32'h0000_0003, 32'hFFFF_FFFB, 4'b0111, obs, lat);
        e = sb.pop_front();
        n_cmp++; if (obs !== e || lat != 5) begin n_bad++;
            $display("FAIL slt_notless got %h/%b%b%b lat %0d want %h/%b%b%b lat 5", obs.res, obs.zero, obs.cout, obs.ovf, lat, e.res, e.zero, e.cout, e.ovf); end
    endtask

    task automatic test_nor_ignore;
        exp_t obs, e;
        int   n_done, lat;
        obs = '0; n_done = 0; lat = -1;
        issue(32'h0F0F_0F0F, 32'h00FF_00FF, CTRL_NOR, 1'b1);
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1) begin
                n_done++; lat = c; obs = {res, zero, cout, ovf};
            end
            if (c == 2) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_run got %b want 1", busy); end
            end
            start = (c == 1 || c == 2);
            a = 32'h1234_5678; b = 32'h1111_1111; ctrl = CTRL_ADD;
            @(negedge clk);
        end
        start = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (n_done != 1) begin n_bad++; $display("FAIL nor_done_count got %0d want 1", n_done); end
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL nor_latency got %0d want 5", lat); end
        n_cmp++; if (obs !== e) begin n_bad++;
            $display("FAIL nor_result got %h/%b%b%b want %h/%b%b%b", obs.res, obs.zero, obs.cout, obs.ovf, e.res, e.zero, e.cout, e.ovf); end
    endtask

    task automatic test_reset_mid;
        exp_t obs, e;
        int   lat;
        issue(32'h7FFF_FFFF, 32'h0000_0001, CTRL_ADD, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midreset_done got %b want 0", done); end
        n_cmp++; if (res !== 32'h0) begin n_bad++; $display("FAIL midreset_result got %h want 0", res); end
        n_cmp++; if (zero !== 1'b1) begin n_bad++; $display("FAIL midreset_zero got %b want 1", zero); end
        n_cmp++; if (cout !== 1'b0) begin n_bad++; $display("FAIL midreset_cout got %b want 0", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL midreset_ovf got %b want 0", ovf); end
        @(negedge clk);
        rst = 1'b0;
        a = 32'hFFFF_0000; b = 32'h0FF0_0FF0; ctrl = CTRL_AND; start = 1'b1;
        sb.push_back(model(a, b, ctrl));
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        obs = {res, zero, cout, ovf};
        e = sb.pop_front();
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL and_after_reset_latency got %0d want 5", lat); end
        n_cmp++; if (obs !== e) begin n_bad++;
            $display("FAIL and_after_reset got %h/%b%b%b want %h/%b%b%b", obs.res, obs.zero, obs.cout, obs.ovf, e.res, e.zero, e.cout, e.ovf); end
    endtask

    task automatic test_random_ops;
        logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1010};
        exp_t obs, e;
        int   lat;
        for (int i = 0; i < 16; i++) begin
            run_op($urandom, (i % 4 == 0) ? 32'h0 : $urandom, ops[i % 8], obs, lat);
            e = sb.pop_front();
            n_cmp++; if (obs !== e || lat != 5) begin n_bad++;
                $display("FAIL random_op%0d ctrl %b got %h/%b%b%b lat %0d want %h/%b%b%b lat 5", i, ops[i % 8], obs.res, obs.zero, obs.cout, obs.ovf, lat, e.res, e.zero, e.cout, e.ovf); end
        end
    endtask

    task automatic test_back_to_back;
        exp_t obs, e;
        int   n_done, prev;
        n_done = 0; prev = -1;
        @(negedge clk);
        a = 32'h89AB_CDEF; b = 32'h7654_3210; ctrl = CTRL_SUB; start = 1'b1;
        e = model(a, b, ctrl);
        for (int c = -1; c < 20; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                obs = {res, zero, cout, ovf};
                n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL held_start_result got %h want %h", obs.res, e.res); end
                if (prev >= 0) begin
                    n_cmp++; if (c - prev != 6) begin n_bad++; $display("FAIL held_start_gap got %0d want 6", c - prev); end
                end
                prev = c;
            end
        end
        start = 1'b0;
        n_cmp++; if (n_done != 3) begin n_bad++; $display("FAIL held_start_count got %0d want 3", n_done); end
    endtask

    task automatic test_single_slice;
        logic [10:0] want [2] = '{{8'h00, 3'b110}, {8'h7F, 3'b011}};
        logic [7:0]  xs [2] = '{8'hFF, 8'h80};
        logic [3:0]  cs [2] = '{CTRL_ADD, CTRL_SUB};
        int          lat;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a8 = xs[i]; b8 = 8'h01; ctrl8 = cs[i]; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            lat = 0;
            while (done8 !== 1'b1 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL single_slice_latency%0d got %0d want 2", i, lat); end
            n_cmp++; if ({res8, zero8, cout8, ovf8} !== want[i]) begin n_bad++;
                $display("FAIL single_slice_op%0d got %h want %h", i, {res8, zero8, cout8, ovf8}, want[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_arith;
        test_slt;
        test_nor_ignore;
        test_reset_mid;
        test_random_ops;
        test_back_to_back;
        test_single_slice;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
